// File: rtl/mult_share_pkg.sv
// Shared types for the multiplier-sharing arbiter: FSM states, ID width helper,
// and the response record.
package mult_share_pkg;

  typedef enum logic [4:0] {
    StIdle     = 5'b00001,
    StIssue    = 5'b00010,
    StWaitBusy = 5'b00100,
    StWaitDone = 5'b01000,
    StRespond  = 5'b10000
  } state_e;

  localparam int unsigned MaxK     = 16;
  localparam int unsigned MaxIdW   = 4;
  localparam int unsigned MaxProdW = 64;

  function automatic int unsigned id_width(input int unsigned k);
    return (k < 2) ? 1 : $clog2(k);
  endfunction

  typedef struct packed {
    logic [MaxIdW-1:0]   id;
    logic [MaxProdW-1:0] product;
  } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, wrapping modulo K. The pointer register lives in the parent.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter  int unsigned K   = 4,
  localparam int unsigned IdW = id_width(K)
) (
  input  logic [K-1:0]   i_req,
  input  logic [IdW-1:0] i_ptr,
  input  logic           i_en,
  output logic [K-1:0]   o_gnt,
  output logic [IdW-1:0] o_idx,
  output logic           o_valid
);

  always_comb begin
    logic [IdW-1:0] w_idx;
    logic           w_found;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < K; i++) begin
      w_idx = IdW'((32'(i_ptr) + i) % K);
      if (i_en && !w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_idx        = w_idx;
        o_gnt[w_idx] = 1'b1;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential start/ready multiplier among K requesters with
// round-robin grant and a tagged, backpressured response channel.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter  int unsigned N    = 4,
  parameter  int unsigned K    = 4,
  localparam int unsigned ID_W = id_width(K)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [K-1:0]      req_valid,
  output logic [K-1:0]      req_ready,
  input  logic [K*N-1:0]    req_a,
  input  logic [K*N-1:0]    req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ID_W-1:0]   resp_id,
  output logic [2*N-1:0]    resp_product,
  output logic              mul_start,
  output logic [N-1:0]      mul_multiplicand,
  output logic [N-1:0]      mul_multiplier,
  input  logic              mul_ready,
  input  logic [2*N-1:0]    mul_product
);

  state_e          r_state;
  state_e          w_state_next;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_id;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [2*N-1:0]  r_product;

  logic [K-1:0]    w_gnt;
  logic [ID_W-1:0] w_gnt_idx;
  logic            w_gnt_valid;
  logic            w_arb_en;
  logic            w_accept;
  logic [N-1:0]    w_sel_a;
  logic [N-1:0]    w_sel_b;
  logic [ID_W-1:0] w_ptr_next;

  // Gating with reset keeps a request from being acknowledged in a reset cycle.
  assign w_arb_en = (r_state == StIdle) && mul_ready && !reset;
  assign w_accept = w_arb_en && w_gnt_valid;

  rr_arbiter #(
    .K (K)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .i_en    (w_arb_en),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (w_gnt[i]) begin
        w_sel_a = req_a[i*N +: N];
        w_sel_b = req_b[i*N +: N];
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == ID_W'(K - 1)) ? '0 : w_gnt_idx + ID_W'(1);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (w_accept) w_state_next = StIssue;
      StIssue:    w_state_next = StWaitBusy;
      StWaitBusy: if (!mul_ready) w_state_next = StWaitDone;
      StWaitDone: if (mul_ready) w_state_next = StRespond;
      StRespond:  if (resp_ready) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= StIdle;
      r_rr_ptr  <= '0;
      r_id      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_next;
      // Operands change only on acceptance, so they stay put while the
      // multiplier loads them in the cycle after the start pulse.
      if (w_accept) begin
        r_a      <= w_sel_a;
        r_b      <= w_sel_b;
        r_id     <= w_gnt_idx;
        r_rr_ptr <= w_ptr_next;
      end
      if ((r_state == StWaitDone) && mul_ready) begin
        r_product <= mul_product;
      end
    end
  end

  assign req_ready        = w_gnt;
  assign mul_start        = (r_state == StIssue) && !reset;
  assign resp_valid       = (r_state == StRespond) && !reset;
  assign resp_id          = r_id;
  assign resp_product     = r_product;
  assign mul_multiplicand = r_a;
  assign mul_multiplier   = r_b;

endmodule
